des_encrypt_engine: RTL and testbench



---
 rtl/des_encrypt_engine.sv | 209 ++++++++++++++++++++
 tb/tb_des_encrypt_engine.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_encrypt_engine.sv
// Iterative DES engine: one Feistel round per clock, subkeys generated on the fly.
// Build option: define DES_DUAL_MODE_EN to add the decrypt port (reverse subkey order).
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready + data_in, encryption_key (+ decrypt) : block input handshake
//   out_valid/out_ready + data_out                          : registered result handshake
module des_encrypt_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [63:0] encryption_key,
`ifdef DES_DUAL_MODE_EN
    input  logic        decrypt,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out
);

    // Tables use DES bit numbering: DES bit n lives at bus bit (width - n).
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
        24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Each S-box is 64 nibbles, row-major (row*16+col), entry 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[j])];
        return y;
    endfunction

    // FP is the inverse of IP, so scatter through the IP table.
    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[6'(64 - IP_T[j])] = x[6'(63 - j)];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[j])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[j])];
        return y;
    endfunction

    function automatic logic [47:0] e_perm(input logic [31:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_T[j])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_T[j])];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  b;
        logic [5:0]  idx;
        x = e_perm(r) ^ k;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            b   = x[6'(47 - 6 * i) -: 6];
            // Outer bits pick the row, inner four the column.
            idx = {b[5], b[0], b[4:1]};
            s[5'(31 - 4 * i) -: 4] = SBOX[i][8'(255 - 4 * int'(idx)) -: 4];
        end
        return p_perm(s);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
        return n[1] ? {x[25:0], x[27:26]} : (n[0] ? {x[26:0], x[27]} : x);
    endfunction

`ifdef DES_DUAL_MODE_EN
    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
        return n[1] ? {x[1:0], x[27:2]} : (n[0] ? {x[0], x[27:1]} : x);
    endfunction
`endif

    state_t      state, state_n;
    logic [31:0] l_q, r_q, l_nx, r_nx;
    logic [27:0] c_q, d_q, c_nx, d_nx;
    logic [3:0]  rnd;
    logic [1:0]  shift;
    logic [47:0] k_rnd;
    logic [63:0] data_q;
    logic        accept;
`ifdef DES_DUAL_MODE_EN
    logic        dec_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = ROUND;
            end
            ROUND: if (rnd == 4'd15) state_n = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign data_out = data_q;

    always_comb begin
        shift = (rnd == 4'd0 || rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) ? 2'd1 : 2'd2;
        c_nx  = rotl(c_q, shift);
        d_nx  = rotl(d_q, shift);
`ifdef DES_DUAL_MODE_EN
        // SHIFT[16-rnd] equals SHIFT[rnd] for rnd 1..15, so only round 0 differs.
        if (dec_q) begin
            c_nx = rotr(c_q, (rnd == 4'd0) ? 2'd0 : shift);
            d_nx = rotr(d_q, (rnd == 4'd0) ? 2'd0 : shift);
        end
`endif
        k_rnd = pc2_perm({c_nx, d_nx});
        l_nx  = r_q;
        r_nx  = l_q ^ feistel(r_q, k_rnd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_q    <= '0;
            r_q    <= '0;
            c_q    <= '0;
            d_q    <= '0;
            rnd    <= '0;
            data_q <= '0;
`ifdef DES_DUAL_MODE_EN
            dec_q  <= 1'b0;
`endif
        end else if (accept) begin
            {l_q, r_q} <= ip_perm(data_in);
            {c_q, d_q} <= pc1_perm(encryption_key);
            rnd        <= '0;
`ifdef DES_DUAL_MODE_EN
            dec_q      <= decrypt;
`endif
        end else if (state == ROUND) begin
            l_q <= l_nx;
            r_q <= r_nx;
            c_q <= c_nx;
            d_q <= d_nx;
            rnd <= rnd + 4'd1;
            // Last round skips the L/R swap before FP.
            if (rnd == 4'd15) data_q <= fp_perm({r_nx, l_nx});
        end
    end

endmodule

// File: tb/tb_des_encrypt_engine.sv
// Testbench for des_encrypt_engine: directed handshake scenarios plus random blocks
// checked against a table-driven DES model with a precomputed key schedule.
module tb_des_encrypt_engine;

    localparam int IP_M [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_M [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int E_M [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
        24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_M [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int PC1_M [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_M [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SB [8][4][16] = '{
        '{'{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
          '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
          '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
          '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}},
        '{'{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10},
          '{3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5},
          '{0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15},
          '{13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9}},
        '{'{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8},
          '{13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1},
          '{13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7},
          '{1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12}},
        '{'{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15},
          '{13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9},
          '{10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4},
          '{3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14}},
        '{'{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9},
          '{14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6},
          '{4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14},
          '{11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3}},
        '{'{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11},
          '{10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8},
          '{9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6},
          '{4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13}},
        '{'{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1},
          '{13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6},
          '{1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2},
          '{6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12}},
        '{'{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7},
          '{1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2},
          '{7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8},
          '{2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}}};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] data_in = '0;
    logic [63:0] encryption_key = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] data_out;
`ifdef DES_DUAL_MODE_EN
    logic        decrypt = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    des_encrypt_engine dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_in        (data_in),
        .encryption_key (encryption_key),
`ifdef DES_DUAL_MODE_EN
        .decrypt        (decrypt),
`endif
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_out       (data_out)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] m_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_M[j])];
        return y;
    endfunction

    function automatic logic [63:0] m_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_M[j])];
        return y;
    endfunction

    function automatic logic [55:0] m_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_M[j])];
        return y;
    endfunction

    function automatic logic [47:0] m_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_M[j])];
        return y;
    endfunction

    function automatic logic [47:0] m_e(input logic [31:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_M[j])];
        return y;
    endfunction

    function automatic logic [31:0] m_p(input logic [31:0] x);
        logic [31:0] y;
        for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_M[j])];
        return y;
    endfunction

    function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [5:0]  six;
        e = m_e(r) ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = e[6'(47 - 6 * b) -: 6];
            s[5'(31 - 4 * b) -: 4] = 4'(SB[b][{six[5], six[0]}][six[4:1]]);
        end
        return m_p(s);
    endfunction

    // Full key schedule first, then 16 rounds; decryption walks the schedule backwards.
    function automatic logic [63:0] des_model(input logic [63:0] k, input logic [63:0] pt,
                                              input logic dec);
        logic [47:0] sub [16];
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] x;
        logic [31:0] l, r, t;
        cd = m_pc1(k);
        c  = cd[55:28];
        d  = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < SHIFTS[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            sub[i] = m_pc2({c, d});
        end
        x = m_ip(pt);
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ m_f(r, dec ? sub[15 - i] : sub[i]);
            l = t;
        end
        return m_fp({r, l});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for out_valid, counting cycles since the accept edge.
    task automatic wait_done(input string tag, inout int lat);
        while (out_valid !== 1'b1 && lat < 40) begin
            check({tag, "_busy"}, {62'd0, in_ready, out_valid}, 64'd0);
            step();
            lat++;
        end
    endtask

    task automatic run_block(input logic [63:0] k, input logic [63:0] pt, input logic dec,
                             input int hold, input string tag, output logic [63:0] obs);
        logic [63:0] exp;
        int          lat;
        exp       = des_model(k, pt, dec);
        out_ready = (hold == 0);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        in_valid       = 1'b1;
        encryption_key = k;
        data_in        = pt;
`ifdef DES_DUAL_MODE_EN
        decrypt        = dec;
`endif
        step();
        in_valid       = 1'b0;
        encryption_key = {$urandom, $urandom};
        data_in        = {$urandom, $urandom};
        lat = 0;
        wait_done(tag, lat);
        check({tag, "_latency"}, 64'(lat), 64'd16);
        check({tag, "_data"}, data_out, exp);
        obs = data_out;
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_flags"}, {62'd0, in_ready, out_valid}, 64'd1);
            check({tag, "_hold_data"}, data_out, exp);
        end
        out_ready = 1'b1;
        step();
        check({tag, "_release"}, {62'd0, in_ready, out_valid}, 64'd2);
        out_ready = 1'b0;
    endtask

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;

    initial begin
        logic [63:0] obs, ka, kb, a, b, pt, ct;
        int          lat;

        rst = 1'b1;
        step();
        step();
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_data_out", data_out, 64'd0);
        rst = 1'b0;
        step();

        run_block(KAT_KEY, KAT_PT, 1'b0, 0, "kat", obs);
        check("kat_const", obs, 64'h85E813540F0AB405);

        run_block(64'd0, 64'd0, 1'b0, 20, "zero", obs);
        check("zero_const", obs, 64'h8CA64DE9C1B123A7);

        // Second block offered while the first is still running.
        ka = {$urandom, $urandom};
        a  = {$urandom, $urandom};
        kb = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        check("busy_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid       = 1'b1;
        encryption_key = ka;
        data_in        = a;
        step();
        in_valid = 1'b0;
        lat = 0;
        repeat (5) begin
            step();
            lat++;
        end
        in_valid       = 1'b1;
        encryption_key = kb;
        data_in        = b;
        out_ready      = 1'b1;
        wait_done("busy_a", lat);
        check("busy_a_latency", 64'(lat), 64'd16);
        check("busy_a_data", data_out, des_model(ka, a, 1'b0));
        step();
        check("busy_ready_back", {62'd0, in_ready, out_valid}, 64'd2);
        step();
        in_valid = 1'b0;
        lat = 0;
        wait_done("busy_b", lat);
        check("busy_b_latency", 64'(lat), 64'd16);
        check("busy_b_data", data_out, des_model(kb, b, 1'b0));
        step();
        check("busy_b_release", {62'd0, in_ready, out_valid}, 64'd2);
        out_ready = 1'b0;

        // Reset while round 7 is about to execute.
        in_valid       = 1'b1;
        encryption_key = KAT_KEY;
        data_in        = 64'hFEDCBA9876543210;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        check("rst_mid_flags", {62'd0, in_ready, out_valid}, 64'd2);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        check("rst_mid_idle", {62'd0, in_ready, out_valid}, 64'd2);
        out_ready = 1'b0;
        run_block(KAT_KEY, KAT_PT, 1'b0, 0, "post_rst", obs);
        check("post_rst_const", obs, 64'h85E813540F0AB405);

        for (int i = 0; i < 12; i++) begin
            run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0,
                      int'($urandom_range(0, 3)), "rand", obs);
        end

`ifdef DES_DUAL_MODE_EN
        run_block(KAT_KEY, 64'h85E813540F0AB405, 1'b1, 0, "dec_kat", obs);
        check("dec_kat_const", obs, KAT_PT);
        for (int i = 0; i < 6; i++) begin
            ka = {$urandom, $urandom};
            pt = {$urandom, $urandom};
            run_block(ka, pt, 1'b0, 0, "rt_enc", ct);
            run_block(ka, ct, 1'b1, int'($urandom_range(0, 2)), "rt_dec", obs);
            check("roundtrip", obs, pt);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
